seq_event_monitor: RTL and testbench



---
 rtl/seq_event_monitor_pkg.sv | 22 ++
 rtl/seq_event_monitor_sat_counter.sv | 43 ++++
 rtl/seq_event_monitor.sv | 141 ++++++++++++++
 tb/tb_seq_event_monitor.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/seq_event_monitor_pkg.sv
// Shared definitions for the sequence event monitor.
//   state_t            : window FSM state encoding (IDLE / WINDOW / ALARM)
//   DEF_*              : default parameter values for the monitor
//   max2()             : helper used to size the shared timer width
package seq_mon_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WINDOW = 2'd1,
      ALARM  = 2'd2
   } state_t;

   localparam int DEF_CNT_W    = 8;
   localparam int DEF_WIN_LEN  = 16;
   localparam int DEF_THRESH   = 3;
   localparam int DEF_HOLD_LEN = 4;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/seq_event_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk   : clock
//   rst   : asynchronous active-high reset
//   inc   : count one when high (ignored once saturated)
//   clr   : synchronous clear, wins over inc
//   count : current count
//   sat   : high while count is all-ones (registered with count)
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count,
   output logic         sat
);

   logic [W-1:0] count_q;
   logic         sat_q;
   logic [W-1:0] count_inc;

   assign count_inc = count_q + W'(1);

   // NOTE: sequential state is written with non-blocking assignments only,
   // so every register samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         sat_q   <= 1'b0;
      end else if (clr) begin
         count_q <= '0;
         sat_q   <= 1'b0;
      end else if (inc && !sat_q) begin
         count_q <= count_inc;
         sat_q   <= (count_inc == {W{1'b1}});
      end
   end

   assign count = count_q;
   assign sat   = sat_q;

endmodule

// File: rtl/seq_event_monitor.sv
// Event monitor downstream of a "101" sequence detector.
//   clk         : clock
//   rst         : asynchronous active-high reset
//   z           : detection level from the detector (rising edge = event)
//   clr         : synchronous clear of counters and FSM
//   total_cnt   : saturating count of all events
//   sat         : total_cnt is all-ones
//   win_cnt     : events counted in the current window
//   alarm       : high for HOLD_LEN cycles after THRESH events in WIN_LEN cycles
//   alarm_pulse : one-cycle strobe on alarm entry
module seq_event_monitor
   import seq_mon_pkg::*;
#(
   parameter int CNT_W    = DEF_CNT_W,
   parameter int WIN_LEN  = DEF_WIN_LEN,
   parameter int THRESH   = DEF_THRESH,
   parameter int HOLD_LEN = DEF_HOLD_LEN
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             z,
   input  logic             clr,
   output logic [CNT_W-1:0] total_cnt,
   output logic             sat,
   output logic [CNT_W-1:0] win_cnt,
   output logic             alarm,
   output logic             alarm_pulse
);

   localparam int TMR_W = $clog2(max2(WIN_LEN, HOLD_LEN));

   // The window timer starts at WIN_LEN-2 so that, counting the opening
   // edge, the window spans exactly WIN_LEN sampling edges.
   localparam logic [TMR_W-1:0] WIN_INIT  = TMR_W'(WIN_LEN - 2);
   localparam logic [TMR_W-1:0] HOLD_INIT = TMR_W'(HOLD_LEN - 1);
   localparam logic [CNT_W-1:0] THRESH_C  = CNT_W'(THRESH);

   state_t           state_q;
   logic             z_d_q;
   logic [CNT_W-1:0] win_cnt_q;
   logic [TMR_W-1:0] win_timer_q;
   logic [TMR_W-1:0] hold_timer_q;
   logic             alarm_q;
   logic             alarm_pulse_q;

   logic             evt;
   logic [CNT_W-1:0] win_cnt_inc;

   assign evt         = z & ~z_d_q;
   assign win_cnt_inc = win_cnt_q + CNT_W'(1);

   // Edge-detect register keeps tracking z through clr so a level held
   // across the clear is not recounted afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) z_d_q <= 1'b0;
      else     z_d_q <= z;
   end

   sat_counter #(.W(CNT_W)) u_total (
      .clk   (clk),
      .rst   (rst),
      .inc   (evt),
      .clr   (clr),
      .count (total_cnt),
      .sat   (sat)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         win_cnt_q     <= '0;
         win_timer_q   <= '0;
         hold_timer_q  <= '0;
         alarm_q       <= 1'b0;
         alarm_pulse_q <= 1'b0;
      end else if (clr) begin
         state_q       <= IDLE;
         win_cnt_q     <= '0;
         win_timer_q   <= '0;
         hold_timer_q  <= '0;
         alarm_q       <= 1'b0;
         alarm_pulse_q <= 1'b0;
      end else begin
         alarm_pulse_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (evt) begin
                  if (THRESH == 1) begin
                     state_q       <= ALARM;
                     win_cnt_q     <= THRESH_C;
                     hold_timer_q  <= HOLD_INIT;
                     alarm_q       <= 1'b1;
                     alarm_pulse_q <= 1'b1;
                  end else begin
                     state_q     <= WINDOW;
                     win_cnt_q   <= CNT_W'(1);
                     win_timer_q <= WIN_INIT;
                  end
               end
            end
            WINDOW: begin
               // An event on the last window edge is counted before expiry.
               if (evt && (win_cnt_inc == THRESH_C)) begin
                  state_q       <= ALARM;
                  win_cnt_q     <= win_cnt_inc;
                  hold_timer_q  <= HOLD_INIT;
                  alarm_q       <= 1'b1;
                  alarm_pulse_q <= 1'b1;
               end else if (win_timer_q == '0) begin
                  state_q   <= IDLE;
                  win_cnt_q <= '0;
               end else begin
                  win_timer_q <= win_timer_q - TMR_W'(1);
                  if (evt) win_cnt_q <= win_cnt_inc;
               end
            end
            ALARM: begin
               // Events here only reach total_cnt; the exit edge never
               // opens a new window.
               if (hold_timer_q == '0) begin
                  state_q   <= IDLE;
                  win_cnt_q <= '0;
                  alarm_q   <= 1'b0;
               end else begin
                  hold_timer_q <= hold_timer_q - TMR_W'(1);
               end
            end
            default: begin
               state_q   <= IDLE;
               win_cnt_q <= '0;
               alarm_q   <= 1'b0;
            end
         endcase
      end
   end

   assign win_cnt     = win_cnt_q;
   assign alarm       = alarm_q;
   assign alarm_pulse = alarm_pulse_q;

endmodule

// File: tb/tb_seq_event_monitor.sv
// Directed self-checking bench for seq_event_monitor (default parameters:
// CNT_W=8, WIN_LEN=16, THRESH=3, HOLD_LEN=4).
module tb_seq_event_monitor;

   logic       clk = 1'b0;
   logic       rst;
   logic       z;
   logic       clr;
   logic [7:0] total_cnt;
   logic       sat;
   logic [7:0] win_cnt;
   logic       alarm;
   logic       alarm_pulse;

   int total = 0;
   int bad   = 0;

   seq_event_monitor dut (
      .clk         (clk),
      .rst         (rst),
      .z           (z),
      .clr         (clr),
      .total_cnt   (total_cnt),
      .sat         (sat),
      .win_cnt     (win_cnt),
      .alarm       (alarm),
      .alarm_pulse (alarm_pulse)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Drive z, let one rising edge sample it, then look 1 time unit later.
   task automatic step(input logic zv);
      z = zv;
      @(posedge clk);
      #1;
   endtask

   task automatic clr_step();
      clr = 1'b1;
      step(1'b0);
      clr = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      z   = 1'b0;
      clr = 1'b0;
      #12;
      check("rst_total", total_cnt, 0);
      check("rst_win", win_cnt, 0);
      check("rst_alarm", alarm, 0);
      check("rst_pulse", alarm_pulse, 0);
      check("rst_sat", sat, 0);
      rst = 1'b0;

      // Pulses at edges 0, 8, 15: threshold reached on the last window edge.
      step(1'b1);
      check("a_e0_win", win_cnt, 1);
      check("a_e0_total", total_cnt, 1);
      repeat (7) step(1'b0);
      step(1'b1);
      check("a_e8_win", win_cnt, 2);
      repeat (6) step(1'b0);
      check("a_e14_win", win_cnt, 2);
      check("a_e14_alarm", alarm, 0);
      step(1'b1);
      check("a_e15_alarm", alarm, 1);
      check("a_e15_pulse", alarm_pulse, 1);
      check("a_e15_total", total_cnt, 3);
      check("a_e15_win", win_cnt, 3);
      step(1'b0);
      check("a_e16_alarm", alarm, 1);
      check("a_e16_pulse", alarm_pulse, 0);
      check("a_e16_win", win_cnt, 3);
      step(1'b0);
      check("a_e17_alarm", alarm, 1);
      step(1'b0);
      check("a_e18_alarm", alarm, 1);
      step(1'b0);
      check("a_e19_alarm", alarm, 0);
      check("a_e19_win", win_cnt, 0);

      // Pulses at edges 0, 8, 16: window expires at edge 15, 16 reopens.
      clr_step();
      check("b_clr_total", total_cnt, 0);
      step(1'b1);
      repeat (7) step(1'b0);
      step(1'b1);
      repeat (6) step(1'b0);
      check("b_e14_win", win_cnt, 2);
      step(1'b0);
      check("b_e15_win", win_cnt, 0);
      check("b_e15_alarm", alarm, 0);
      step(1'b1);
      check("b_e16_win", win_cnt, 1);
      check("b_e16_total", total_cnt, 3);
      check("b_e16_alarm", alarm, 0);

      // z held high for 5 cycles is one event; then clr beats a rising edge.
      clr_step();
      repeat (5) step(1'b1);
      check("c_hold_total", total_cnt, 1);
      check("c_hold_win", win_cnt, 1);
      step(1'b0);
      step(1'b1);
      check("c_second_win", win_cnt, 2);
      check("c_second_total", total_cnt, 2);
      step(1'b0);
      clr = 1'b1;
      step(1'b1);
      clr = 1'b0;
      check("c_clr_total", total_cnt, 0);
      check("c_clr_win", win_cnt, 0);
      check("c_clr_alarm", alarm, 0);
      step(1'b0);
      step(1'b1);
      check("c_after_win", win_cnt, 1);
      check("c_after_total", total_cnt, 1);

      // 260 isolated pulses: saturate at 255, never wrap.
      clr_step();
      for (int i = 1; i <= 260; i++) begin
         step(1'b1);
         check($sformatf("d_total_%0d", i), total_cnt, (i < 255) ? i : 255);
         check($sformatf("d_sat_%0d", i), sat, (i >= 255) ? 1 : 0);
         step(1'b0);
      end

      // Asynchronous reset in the middle of ALARM.
      clr_step();
      step(1'b1);
      step(1'b0);
      step(1'b1);
      step(1'b0);
      step(1'b1);
      check("e_alarm_on", alarm, 1);
      check("e_pulse_on", alarm_pulse, 1);
      z = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("e_rst_alarm", alarm, 0);
      check("e_rst_pulse", alarm_pulse, 0);
      check("e_rst_total", total_cnt, 0);
      check("e_rst_win", win_cnt, 0);
      check("e_rst_sat", sat, 0);
      #2 rst = 1'b0;
      step(1'b1);
      check("e_fresh_win", win_cnt, 1);
      check("e_fresh_total", total_cnt, 1);
      check("e_fresh_alarm", alarm, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
